// File: rtl/tx_frame_sched.sv
// tx_frame_sched
// Pulls whole frames out of an RX byte FIFO and hands them to a MAC. Frame
// lengths arrive separately through a small length queue. Frames whose length
// is 0 or larger than MAX_LEN are drained from the FIFO and counted as dropped.
// Every sent or dropped frame is followed by an inter-frame gap of IFG_CYCLES.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   frm_len_in/_valid   push one frame length into the length queue
//   fifo_empty/_rd_data RX FIFO status and head byte (first-word fall-through)
//   fifo_rd             pop the RX FIFO head byte
//   pause_hold          blocks the start of new frames (drops still proceed)
//   tx_mac_*            byte stream to the MAC (valid/ready handshake, last)
//   lq_full/_overflow   length queue full, sticky lost-push flag
//   frames_sent         wrapping count of fully sent frames
//   frames_dropped      saturating count of dropped frames
//   busy                FSM is not idle
module tx_frame_sched #(
    parameter int LQ_DEPTH   = 4,
    parameter int IFG_CYCLES = 12,
    parameter int MAX_LEN    = 1514
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] frm_len_in,
    input  logic        frm_len_valid,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_rd_data,
    output logic        fifo_rd,
    input  logic        pause_hold,
    input  logic        tx_mac_ready,
    output logic [7:0]  tx_mac_data,
    output logic        tx_mac_valid,
    output logic        tx_mac_last,
    output logic        lq_full,
    output logic        lq_overflow,
    output logic [15:0] frames_sent,
    output logic [7:0]  frames_dropped,
    output logic        busy
);

    localparam int AW = $clog2(LQ_DEPTH);
    localparam int GW = $clog2(IFG_CYCLES + 1);
    localparam logic [AW:0]   LQ_FULL_CNT = (AW + 1)'(LQ_DEPTH);
    localparam logic [15:0]   MAX_LEN_W   = 16'(MAX_LEN);
    localparam logic [GW-1:0] GAP_LOAD    = GW'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, DROP, GAP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   byte_cnt_q, byte_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   sent_q, sent_d;
    logic [7:0]    drop_q, drop_d;

    logic [15:0]   lq_mem [LQ_DEPTH];
    logic [15:0]   head_len;
    logic          head_ok;
    logic          lq_empty;
    logic          lq_pop;
    logic          lq_push;
    logic [7:0]    drop_inc;

    assign lq_empty = (count_q == '0);
    assign lq_full  = (count_q == LQ_FULL_CNT);
    assign head_len = lq_mem[rd_ptr_q];
    assign head_ok  = (head_len != 16'd0) && (head_len <= MAX_LEN_W);
    assign drop_inc = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

    // A push is accepted while full only if the same cycle frees a slot.
    assign lq_push = frm_len_valid && (!lq_full || lq_pop);

    // Frame scheduler: next state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        sent_d       = sent_q;
        drop_d       = drop_q;
        lq_pop       = 1'b0;
        fifo_rd      = 1'b0;
        tx_mac_valid = 1'b0;
        tx_mac_data  = 8'h00;
        tx_mac_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!lq_empty) begin
                    // Bad lengths are drained even while paused so the FIFO
                    // never stays clogged by garbage.
                    if (!head_ok) begin
                        lq_pop     = 1'b1;
                        byte_cnt_d = head_len;
                        state_d    = DROP;
                    end else if (!pause_hold) begin
                        lq_pop     = 1'b1;
                        byte_cnt_d = head_len;
                        state_d    = SEND;
                    end
                end
            end
            SEND: begin
                // A FIFO underrun simply stalls; the frame is never aborted.
                tx_mac_valid = !fifo_empty;
                tx_mac_data  = fifo_rd_data;
                tx_mac_last  = tx_mac_valid && (byte_cnt_q == 16'd1);
                fifo_rd      = tx_mac_valid && tx_mac_ready;
                if (fifo_rd) begin
                    byte_cnt_d = byte_cnt_q - 16'd1;
                    if (byte_cnt_q == 16'd1) begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_LOAD;
                        sent_d    = sent_q + 16'd1;
                    end
                end
            end
            DROP: begin
                if (byte_cnt_q == 16'd0) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                    drop_d    = drop_inc;
                end else begin
                    fifo_rd = !fifo_empty;
                    if (fifo_rd) begin
                        byte_cnt_d = byte_cnt_q - 16'd1;
                        if (byte_cnt_q == 16'd1) begin
                            state_d   = GAP;
                            gap_cnt_d = GAP_LOAD;
                            drop_d    = drop_inc;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Length queue bookkeeping; pointers wrap naturally (power-of-two depth).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (frm_len_valid && !lq_push);
        if (lq_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (lq_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (lq_push && !lq_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (lq_pop && !lq_push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            sent_q     <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            ovf_q      <= ovf_d;
            sent_q     <= sent_d;
            drop_q     <= drop_d;
        end
    end

    // Entry storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (lq_push) begin
            lq_mem[wr_ptr_q] <= frm_len_in;
        end
    end

    assign lq_overflow    = ovf_q;
    assign frames_sent    = sent_q;
    assign frames_dropped = drop_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: doc/tx_frame_sched.md
TX_FRAME_SCHED -- requirements
Module: tx_frame_sched

Interface
REQ-001 Parameter LQ_DEPTH, 4: frame-length queue depth in entries, power of two, at least 2.
REQ-002 Parameter IFG_CYCLES, 12: idle clk cycles inserted after each sent or dropped frame, at least 1.
REQ-003 Parameter MAX_LEN, 1514: largest frame length in bytes that is forwarded; longer frames are drained and dropped.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 frm_len_in  in  16  byte count of one frame already written to the RX FIFO.
REQ-007 frm_len_valid  in  1  one-cycle strobe that pushes frm_len_in into the length queue.
REQ-008 fifo_empty  in  1  RX FIFO empty flag.
REQ-009 fifo_rd_data  in  8  RX FIFO head byte (first-word fall-through), valid while fifo_empty=0.
REQ-010 fifo_rd  out  1  pops the RX FIFO head byte.
REQ-011 pause_hold  in  1  when 1, no new frame is started.
REQ-012 tx_mac_ready  in  1  MAC accepts the current byte.
REQ-013 tx_mac_data  out  8  byte to the MAC.
REQ-014 tx_mac_valid  out  1  tx_mac_data is valid.
REQ-015 tx_mac_last  out  1  marks the final byte of a frame.
REQ-016 lq_full  out  1  length queue holds LQ_DEPTH entries.
REQ-017 lq_overflow  out  1  sticky flag; set when a push is lost.
REQ-018 frames_sent  out  16  count of frames fully sent, wraps at 0xFFFF.
REQ-019 frames_dropped  out  8  count of frames dropped, saturates at 0xFF.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, SEND, DROP and GAP.
REQ-022 IDLE->SEND SHALL occur when the queue is non-empty, pause_hold=0, and the head length is in 1..MAX_LEN; the head entry is popped and the byte counter is loaded with the head length on the transition edge.
REQ-023 IDLE->DROP SHALL occur when the queue is non-empty and the head length is 0 or greater than MAX_LEN, regardless of pause_hold; the head is popped and the counter is loaded with the head length.
REQ-024 In SEND, tx_mac_valid SHALL equal NOT fifo_empty; tx_mac_data SHALL equal fifo_rd_data; fifo_rd SHALL equal tx_mac_valid AND tx_mac_ready; all three are combinational.
REQ-025 In SEND, each accepted byte SHALL decrement the counter; tx_mac_last SHALL be 1 while tx_mac_valid=1 and the counter equals 1.
REQ-026 Acceptance of the byte with tx_mac_last=1 SHALL move the FSM to GAP and increment frames_sent.
REQ-027 The FIFO underrunning inside SEND (fifo_empty=1) SHALL stall with tx_mac_valid=0; the FSM does not abort.
REQ-028 In DROP, fifo_rd SHALL equal NOT fifo_empty and tx_mac_valid SHALL be 0; each pop decrements the counter.
REQ-029 DROP SHALL go to GAP on the pop that brings the counter to 0, or immediately if the length is 0; frames_dropped increments on that transition.
REQ-030 GAP SHALL last exactly IFG_CYCLES cycles with all handshake outputs 0, then return to IDLE.
REQ-031 pause_hold rising during SEND SHALL NOT interrupt the current frame.
REQ-032 The length queue SHALL be a circular buffer with wrapping pointers and an occupancy count of width log2(LQ_DEPTH)+1.
REQ-033 A push and a pop in the same cycle SHALL both take effect and leave the occupancy unchanged, including when the queue is full.
REQ-034 A push while full without a same-cycle pop SHALL be discarded and SHALL set lq_overflow.
REQ-035 Outside SEND and DROP, fifo_rd, tx_mac_valid and tx_mac_last SHALL be 0.

Reset
REQ-036 rst_n=0 SHALL asynchronously force IDLE, empty the queue, and clear the byte counter, GAP counter, lq_overflow, frames_sent and frames_dropped.
REQ-037 While reset is asserted, all outputs SHALL be 0.
REQ-038 Reset asserted in the middle of a frame SHALL abandon that frame without asserting tx_mac_last.
REQ-039 After reset release, RX FIFO contents are not drained by this block.

Verification
REQ-040 Push length 3, FIFO holds AA BB CC, ready=1 -> three beats AA, BB, CC with last on CC; frames_sent=1; busy for 3+12 cycles.
REQ-041 Push length 4, ready toggles 1,0,1,0... -> four accepted bytes, last asserted only on the 4th, fifo_rd never high while ready=0.
REQ-042 Push length 1600, FIFO holds 1600 bytes -> tx_mac_valid stays 0, 1600 pops, frames_dropped=1, then GAP.
REQ-043 Five pushes with no pops (LQ_DEPTH=4) -> lq_full=1 after the 4th push, lq_overflow=1 after the 5th; a push+pop at full keeps occupancy 4.
REQ-044 pause_hold=1 with the queue non-empty -> remains IDLE; release -> SEND on the next edge; pause_hold asserted mid-frame -> frame completes.
REQ-045 rst_n pulsed low after the 2nd byte of a 10-byte frame -> outputs 0 immediately, counters 0, IDLE after release.
